// File: rtl/ex_mem_stage_if.sv
// EX/MEM pipeline channel: upstream beat with control bundle, downstream registered
// copy, flush and the back-pressure counter, bundled for the stage and its environment.
interface ex_mem_stage_if #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             RegWrite;
  logic             MemtoReg;
  logic             MemWrite;
  logic             MemRead;
  logic [XLEN-1:0]  AluResult;
  logic [XLEN-1:0]  Datain;
  logic [RA_W-1:0]  Rd_in;

  logic             out_valid;
  logic             out_ready;
  logic             RegWrite_Out;
  logic             MemtoReg_Out;
  logic             MemWrite_Out;
  logic             MemRead_out;
  logic [XLEN-1:0]  AluOut;
  logic [XLEN-1:0]  DataOut;
  logic [RA_W-1:0]  Rd_out;
  logic [CNT_W-1:0] stall_cnt;

  // Environment side: produces upstream beats and downstream ready.
  modport master (
    output flush, in_valid, RegWrite, MemtoReg, MemWrite, MemRead,
           AluResult, Datain, Rd_in, out_ready,
    input  in_ready, out_valid, RegWrite_Out, MemtoReg_Out, MemWrite_Out,
           MemRead_out, AluOut, DataOut, Rd_out, stall_cnt
  );

  // Stage side.
  modport slave (
    input  flush, in_valid, RegWrite, MemtoReg, MemWrite, MemRead,
           AluResult, Datain, Rd_in, out_ready,
    output in_ready, out_valid, RegWrite_Out, MemtoReg_Out, MemWrite_Out,
           MemRead_out, AluOut, DataOut, Rd_out, stall_cnt
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a 2-entry skid buffer: full throughput, ready
// driven only from registered state, x0 write suppression, flush and stall counting.
module ex_mem_stage #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            reset,
  ex_mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} stateT;

  typedef struct packed {
    logic            regWrite;
    logic            memtoReg;
    logic            memWrite;
    logic            memRead;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] data;
    logic [RA_W-1:0] rd;
  } entryT;

  stateT            state, stateNext;
  entryT            mainQ, skidQ, incoming;
  logic             inReady, outValid, accept, emit;
  logic             loadMain, loadSkid, skidToMain;
  logic [CNT_W-1:0] stallQ;

  assign inReady  = (state != TWO);
  assign outValid = (state != EMPTY);
  assign accept   = bus.in_valid && inReady;
  assign emit     = outValid && bus.out_ready;

  // A write to x0 is architecturally a no-op, so it is dropped at capture.
  assign incoming.regWrite = bus.RegWrite && (bus.Rd_in != '0);
  assign incoming.memtoReg = bus.MemtoReg;
  assign incoming.memWrite = bus.MemWrite;
  assign incoming.memRead  = bus.MemRead;
  assign incoming.alu      = bus.AluResult;
  assign incoming.data     = bus.Datain;
  assign incoming.rd       = bus.Rd_in;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    stateNext  = state;
    loadMain   = 1'b0;
    loadSkid   = 1'b0;
    skidToMain = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          stateNext = ONE;
          loadMain  = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          loadMain = 1'b1;
        end else if (accept) begin
          stateNext = TWO;
          loadSkid  = 1'b1;
        end else if (emit) begin
          stateNext = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          stateNext  = ONE;
          skidToMain = 1'b1;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Flush overrides everything: held entries and the incoming beat are dropped.
    if (bus.flush) begin
      stateNext  = EMPTY;
      loadMain   = 1'b0;
      loadSkid   = 1'b0;
      skidToMain = 1'b0;
    end
  end

  // NOTE: the entry registers are reset too, because the data outputs must read 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state <= EMPTY;
      mainQ <= '0;
      skidQ <= '0;
    end else begin
      state <= stateNext;
      if (loadMain)        mainQ <= incoming;
      else if (skidToMain) mainQ <= skidQ;
      if (loadSkid)        skidQ <= incoming;
    end
  end

  // Counts edges where a beat is held but downstream refuses it; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallQ <= '0;
    end else if (outValid && !bus.out_ready && (stallQ != '1)) begin
      stallQ <= stallQ + CNT_W'(1);
    end
  end

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = outValid;
  assign bus.RegWrite_Out = mainQ.regWrite && outValid;
  assign bus.MemtoReg_Out = mainQ.memtoReg && outValid;
  assign bus.MemWrite_Out = mainQ.memWrite && outValid;
  assign bus.MemRead_out  = mainQ.memRead  && outValid;
  assign bus.AluOut       = mainQ.alu;
  assign bus.DataOut      = mainQ.data;
  assign bus.Rd_out       = mainQ.rd;
  assign bus.stall_cnt    = stallQ;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: table of per-cycle vectors plus hand sequences for
// mid-operation reset and stall counter saturation on a narrow-counter instance.
module tb_ex_mem_stage;

  localparam logic [63:0] DMASK = 64'hA5A5_0000_FFFF_5A5A;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.XLEN(64), .RA_W(5), .CNT_W(16)) bus ();
  ex_mem_stage_if #(.XLEN(64), .RA_W(5), .CNT_W(4))  bus2 ();

  ex_mem_stage #(.XLEN(64), .RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  ex_mem_stage #(.XLEN(64), .RA_W(5), .CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    logic        inV, oR, fl, rw, mtr, mw, mr;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        eInReady, eOutValid;
    logic [3:0]  eCtrl;   // {RegWrite, MemtoReg, MemWrite, MemRead}
    logic [63:0] eAlu;
    logic [4:0]  eRd;
    int          eStall;
  } vecT;

  vecT vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vecT v);
    bus.in_valid  = v.inV;
    bus.out_ready = v.oR;
    bus.flush     = v.fl;
    bus.RegWrite  = v.rw;
    bus.MemtoReg  = v.mtr;
    bus.MemWrite  = v.mw;
    bus.MemRead   = v.mr;
    bus.AluResult = v.alu;
    bus.Datain    = v.alu ^ DMASK;
    bus.Rd_in     = v.rd;
  endtask

  function automatic logic [3:0] ctrl1();
    return {bus.RegWrite_Out, bus.MemtoReg_Out, bus.MemWrite_Out, bus.MemRead_out};
  endfunction

  initial begin
    // inV oR fl rw mtr mw mr alu rd | inReady outValid ctrl alu rd stall
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,64'h1234,5'd5,  1'b1,1'b1,4'b1000,64'h1234,5'd5, 0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,64'hBEEF,5'd0,  1'b1,1'b1,4'b0101,64'hBEEF,5'd0, 0};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,5'd0,     1'b1,1'b0,4'b0000,64'hBEEF,5'd0, 0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,64'hA1,5'd1,    1'b1,1'b1,4'b1000,64'hA1,5'd1,   0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,64'hB2,5'd2,    1'b0,1'b1,4'b1000,64'hA1,5'd1,   1};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,64'hC3,5'd3,    1'b0,1'b1,4'b1000,64'hA1,5'd1,   2};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,64'hC3,5'd3,    1'b1,1'b1,4'b1010,64'hB2,5'd2,   2};
    vecs[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,64'hC3,5'd3,    1'b1,1'b1,4'b1001,64'hC3,5'd3,   2};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,5'd0,     1'b1,1'b0,4'b0000,64'hC3,5'd3,   2};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,64'hD4,5'd4,    1'b1,1'b1,4'b1000,64'hD4,5'd4,   2};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,64'hE5,5'd6,    1'b0,1'b1,4'b1000,64'hD4,5'd4,   3};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,64'hF6,5'd7,    1'b1,1'b0,4'b0000,64'hD4,5'd4,   3};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,5'd0,     1'b1,1'b0,4'b0000,64'hD4,5'd4,   3};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,64'h77,5'd9,    1'b1,1'b1,4'b0010,64'h77,5'd9,   3};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,64'h88,5'd10,   1'b1,1'b0,4'b0000,64'h77,5'd9,   3};
    vecs[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,5'd0,     1'b1,1'b0,4'b0000,64'h77,5'd9,   3};

    drive('{default: '0});
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    bus2.RegWrite = 1'b0; bus2.MemtoReg = 1'b0; bus2.MemWrite = 1'b0; bus2.MemRead = 1'b0;
    bus2.AluResult = '0; bus2.Datain = '0; bus2.Rd_in = '0;

    // Reset state
    #2;
    check("rst_inReady",  64'(bus.in_ready), 64'd1);
    check("rst_outValid", 64'(bus.out_valid), 64'd0);
    check("rst_ctrl",     64'(ctrl1()), 64'd0);
    check("rst_alu",      bus.AluOut, 64'd0);
    check("rst_data",     bus.DataOut, 64'd0);
    check("rst_rd",       64'(bus.Rd_out), 64'd0);
    check("rst_stall",    64'(bus.stall_cnt), 64'd0);
    #10 reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_inReady", i),  64'(bus.in_ready),  64'(vecs[i].eInReady));
      check($sformatf("v%0d_outValid", i), 64'(bus.out_valid), 64'(vecs[i].eOutValid));
      check($sformatf("v%0d_ctrl", i),     64'(ctrl1()),        64'(vecs[i].eCtrl));
      check($sformatf("v%0d_alu", i),      bus.AluOut,          vecs[i].eAlu);
      check($sformatf("v%0d_data", i),     bus.DataOut,         vecs[i].eAlu ^ DMASK);
      check($sformatf("v%0d_rd", i),       64'(bus.Rd_out),     64'(vecs[i].eRd));
      check($sformatf("v%0d_stall", i),    64'(bus.stall_cnt),  64'(vecs[i].eStall));
    end

    // Mid-operation reset with both entries full
    drive('{inV:1'b1, oR:1'b0, rw:1'b1, alu:64'h11, rd:5'd1, default:'0});
    @(posedge clk); #1;
    drive('{inV:1'b1, oR:1'b0, rw:1'b1, alu:64'h22, rd:5'd2, default:'0});
    @(posedge clk); #1;
    check("pre_rst_inReady", 64'(bus.in_ready), 64'd0);
    check("pre_rst_stall",   64'(bus.stall_cnt), 64'd4);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_outValid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_inReady",  64'(bus.in_ready), 64'd1);
    check("mid_rst_ctrl",     64'(ctrl1()), 64'd0);
    check("mid_rst_alu",      bus.AluOut, 64'd0);
    check("mid_rst_data",     bus.DataOut, 64'd0);
    check("mid_rst_rd",       64'(bus.Rd_out), 64'd0);
    check("mid_rst_stall",    64'(bus.stall_cnt), 64'd0);
    drive('{oR:1'b1, default:'0});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_outValid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("post_rst_idle",     64'(bus.out_valid), 64'd0);

    // Saturation on the 4-bit counter instance
    bus2.in_valid = 1'b1; bus2.out_ready = 1'b0; bus2.RegWrite = 1'b1;
    bus2.AluResult = 64'h5; bus2.Rd_in = 5'd3;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    check("sat_first", 64'(bus2.stall_cnt), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("sat_ten", 64'(bus2.stall_cnt), 64'd10);
    repeat (10) @(posedge clk);
    #1;
    check("sat_cap",      64'(bus2.stall_cnt), 64'd15);
    check("sat_outValid", 64'(bus2.out_valid), 64'd1);
    check("sat_alu",      bus2.AluOut, 64'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of ALU result and store data.
REQ-002 SHALL have parameter RA_W, default 5, destination register index width.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  kill all held entries and the incoming beat.
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-009 SHALL have port RegWrite, MemtoReg, MemWrite, MemRead  input  1 each  control bundle.
REQ-010 SHALL have port AluResult  input  XLEN  ALU result.
REQ-011 SHALL have port Datain  input  XLEN  store data.
REQ-012 SHALL have port Rd_in  input  RA_W  destination register.
REQ-013 SHALL have port out_valid  output  1  downstream beat present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-015 SHALL have port RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out  output  1 each.
REQ-016 SHALL have ports AluOut, DataOut (XLEN) and Rd_out (RA_W)  output.
REQ-017 SHALL have port stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-018 SHALL implement a 2-entry skid buffer (main, skid) with states EMPTY, ONE, TWO.
REQ-019 SHALL accept a beat when in_valid && in_ready; SHALL emit when out_valid && out_ready.
REQ-020 SHALL drive in_ready = 1 in EMPTY/ONE, 0 in TWO, from registered state only (no in->out combinational path).
REQ-021 SHALL drive out_valid = 1 in ONE/TWO, 0 in EMPTY; outputs always from main entry.
REQ-022 EMPTY: accept -> ONE (beat into main); else stay.
REQ-023 ONE: accept & emit -> ONE (beat into main); accept only -> TWO (beat into skid); emit only -> EMPTY; neither -> stay.
REQ-024 TWO: emit -> ONE (skid moves to main); else stay, contents held unchanged.
REQ-025 Latency SHALL be 1 cycle: beat accepted at edge N appears on outputs after edge N when stage was EMPTY or emitting.
REQ-026 Order SHALL be preserved; no beat duplicated or dropped except by flush.
REQ-027 On capture, RegWrite SHALL be stored as 0 when Rd_in == 0 (x0 write suppression).
REQ-028 When out_valid = 0, all four control outputs SHALL read 0; AluOut, DataOut, Rd_out hold last value.
REQ-029 flush = 1 at an edge SHALL force state EMPTY; incoming beat that cycle is discarded; flush wins over simultaneous accept/emit.
REQ-030 in_ready SHALL be 1 in the cycle after a flush.
REQ-031 stall_cnt SHALL increment by 1 each edge with out_valid && !out_ready, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-032 reset = 0 SHALL immediately (asynchronously) set state EMPTY, out_valid 0, in_ready 1, all data/control outputs 0, stall_cnt 0.
REQ-033 Release of reset SHALL be synchronized externally; first accept possible at first edge with reset = 1.
REQ-034 Reset asserted mid-operation SHALL discard all held entries with no partial emit.

Verification
REQ-035 Reset: reset=0 mid-cycle -> outputs 0, out_valid 0, in_ready 1 before next edge; stall_cnt 0.
REQ-036 Pass-through: out_ready=1, beat AluResult=64'h1234, Rd_in=5, RegWrite=1 -> next cycle out_valid 1, AluOut 64'h1234, Rd_out 5, RegWrite_Out 1.
REQ-037 Back-pressure: out_ready=0, 3 beats A,B,C offered -> A,B accepted, in_ready 0 at C; release out_ready -> A,B,C emitted in order; stall_cnt equals stalled cycles.
REQ-038 x0 suppression: beat Rd_in=0, RegWrite=1, MemRead=1 -> RegWrite_Out 0, MemRead_out 1.
REQ-039 Flush in TWO with simultaneous in_valid -> next cycle out_valid 0, control outputs 0, in_ready 1; no held or incoming beat emitted later.
REQ-040 Saturation: CNT_W=4, out_ready=0 for 20 cycles with one beat held -> stall_cnt stops at 15.
